// File: rtl/seq1101_framer.sv
// seq1101_framer: serial frame transmitter for the 1101 sync-word link.
// Emits guard 00, sync 1101, then the payload MSB-first with zero stuffing.
module seq1101_framer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              sync_mark
);

  localparam int CW = $clog2(DATA_W + 1);

  // State names the kind of bit currently on the line.
  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_SYNC,
    S_DATA,
    S_STUFF
  } state_t;

  state_t            r_state;
  logic              r_ser;
  logic              r_mark;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_bits;
  logic [1:0]        r_cnt;
  logic [2:0]        r_hist;

  state_t            w_state;
  logic              w_ser;
  logic              w_mark;
  logic [DATA_W-1:0] w_shift;
  logic [CW-1:0]     w_bits;
  logic [1:0]        w_cnt;
  logic              w_emit;
  logic              w_go_pay;

  assign data_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ser_out    = r_ser;
  assign sync_mark  = r_mark;

  // Next state and the next line bit; w_emit marks bits that enter hist.
  always_comb begin
    w_state  = r_state;
    w_ser    = 1'b0;
    w_mark   = 1'b0;
    w_shift  = r_shift;
    w_bits   = r_bits;
    w_cnt    = r_cnt;
    w_emit   = 1'b0;
    w_go_pay = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (data_valid && data_ready) begin
          w_state = S_GUARD;
          w_shift = data_in;
          w_bits  = '0;
          w_cnt   = 2'd0;
          w_emit  = 1'b1;
        end
      end
      S_GUARD: begin
        w_emit = 1'b1;
        if (r_cnt == 2'd0) begin
          w_cnt = 2'd1;
        end else begin
          w_state = S_SYNC;
          w_cnt   = 2'd0;
          w_ser   = 1'b1;
        end
      end
      S_SYNC: begin
        unique case (r_cnt)
          2'd0: begin
            w_emit = 1'b1;
            w_cnt  = 2'd1;
            w_ser  = 1'b1;
          end
          2'd1: begin
            w_emit = 1'b1;
            w_cnt  = 2'd2;
          end
          2'd2: begin
            w_emit = 1'b1;
            w_cnt  = 2'd3;
            w_ser  = 1'b1;
            w_mark = 1'b1;
          end
          2'd3: w_go_pay = 1'b1;
        endcase
      end
      S_DATA:  w_go_pay = 1'b1;
      S_STUFF: w_go_pay = 1'b1;
      default: w_state = S_IDLE;
    endcase
    // Payload slot: finish, stuff a 0 after 110, or send the MSB.
    if (w_go_pay) begin
      if (r_bits == CW'(DATA_W)) begin
        w_state = S_IDLE;
      end else if (r_hist == 3'b110) begin
        w_state = S_STUFF;
        w_emit  = 1'b1;
      end else begin
        w_state = S_DATA;
        w_emit  = 1'b1;
        w_ser   = r_shift[DATA_W-1];
        w_shift = r_shift << 1;
        w_bits  = r_bits + CW'(1);
      end
    end
  end

  // State, line and history registers; reset aborts any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ser   <= 1'b0;
      r_mark  <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
      r_cnt   <= 2'd0;
      r_hist  <= 3'b000;
    end else begin
      r_state <= w_state;
      r_ser   <= w_ser;
      r_mark  <= w_mark;
      r_shift <= w_shift;
      r_bits  <= w_bits;
      r_cnt   <= w_cnt;
      if (w_emit) r_hist <= {r_hist[1:0], w_ser};
    end
  end

endmodule

// File: tb/tb_seq1101_framer.sv
// tb_seq1101_framer: directed frames, mid-frame reset and random traffic
// against a 1101 detector and de-stuffing receiver on the line.
module tb_seq1101_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ser_out;
  logic       busy;
  logic       sync_mark;

  int n_cmp = 0;
  int n_bad = 0;

  seq1101_framer #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .busy       (busy),
    .sync_mark  (sync_mark)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: overlapping Moore 1101 detector plus receiver.
  logic [3:0] win = 4'b0000;
  int         det = 0;
  bit         rx_on = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_pay = 8'h00;
  logic [7:0] rx_q[$];
  int         stuff_err = 0;
  int         rb_err = 0;

  always @(negedge clk) begin
    win <= {win[2:0], ser_out};
    if (data_ready && busy) rb_err <= rb_err + 1;
    if ({win[2:0], ser_out} == 4'b1101) begin
      det   <= det + 1;
      rx_on <= 1'b1;
      rx_n  <= 0;
    end else if (rx_on) begin
      if (win[2:0] == 3'b110) begin
        if (ser_out) stuff_err <= stuff_err + 1;
      end else begin
        rx_pay <= {rx_pay[6:0], ser_out};
        if (rx_n == 7) begin
          rx_q.push_back({rx_pay[6:0], ser_out});
          rx_on <= 1'b0;
        end else begin
          rx_n <= rx_n + 1;
        end
      end
    end
  end

  // Sends one word starting just after a negedge and checks the frame.
  task automatic run_frame(input string tag, input logic [7:0] w,
                           input logic [31:0] exp, input int len);
    logic [31:0] cap;
    int bz;
    int mk;
    int mpos;
    int d0;
    cap  = '0;
    bz   = 0;
    mk   = 0;
    mpos = -1;
    d0   = det;
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = ~w;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cap = {cap[30:0], ser_out};
      if (busy) bz++;
      if (sync_mark) begin
        mk++;
        mpos = i;
      end
    end
    @(negedge clk);
    chk({tag, ".bits"}, cap, exp);
    chk({tag, ".busy_len"}, bz, len);
    chk({tag, ".mark_cnt"}, mk, 1);
    chk({tag, ".mark_pos"}, mpos, 5);
    chk({tag, ".ready_after"}, data_ready, 1'b1);
    chk({tag, ".busy_after"}, busy, 1'b0);
    chk({tag, ".ser_idle"}, ser_out, 1'b0);
    #1;
    chk({tag, ".det"}, det - d0, 1);
  endtask

  localparam int NW = 2000;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int t;
    int tmo;
    int nq;
    logic [7:0] exp_q[$];
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst.ser", ser_out, 1'b0);
    chk("rst.ready", data_ready, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.mark", sync_mark, 1'b0);
    reset = 1'b0;
    #1;

    run_frame("f00", 8'h00, 32'b00110100000000, 14);
    run_frame("fA0", 8'hA0, 32'b001101100100000, 15);
    run_frame("fB6", 8'hB6, 32'b0011011001100110, 16);

    d0 = det;
    run_frame("fFF1", 8'hFF, 32'b00110111111111, 14);
    run_frame("fFF2", 8'hFF, 32'b00110111111111, 14);
    chk("b2b.det", det - d0, 2);

    // Abort a frame during its sync bits.
    d0         = det;
    data_in    = 8'h5A;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort.ser", ser_out, 1'b0);
    chk("abort.ready", data_ready, 1'b1);
    chk("abort.busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort.det", det - d0, 0);
    run_frame("post_rst", 8'hA0, 32'b001101100100000, 15);

    // Random words with random idle gaps.
    rx_q.delete();
    d0  = det;
    tmo = 0;
    for (int w = 0; w < NW; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      data_in    = 8'($urandom);
      data_valid = 1'b1;
      exp_q.push_back(data_in);
      t = 0;
      while (!data_ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) tmo++;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data_in    = 8'($urandom);
    end
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rand.timeouts", tmo, 0);
    chk("rand.idle", busy, 1'b0);
    chk("rand.det", det - d0, NW);
    chk("rand.rx_cnt", rx_q.size(), NW);
    nq = (rx_q.size() < NW) ? rx_q.size() : NW;
    for (int i = 0; i < nq; i++) begin
      chk($sformatf("rand.word%0d", i), rx_q[i], exp_q[i]);
    end
    chk("rand.stuff_bits", stuff_err, 0);
    chk("ready_busy_overlap", rb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
